vram_dma_engine: RTL and testbench
==================================

// Module: vram_dma_engine
// PURPOSE
// CPU-programmed block fill/copy engine for the 32Kx16 video RAM. Sits on the RAM address mux beside the CPU,
// directly upstream of the tile and sprite renderers: it bulk-writes the screen buffer, page table and sprite
// table they read. Video fetches always win the bus; the engine yields and resumes. Holds the CPU while active.
// PARAMETERS
// ADDR_W  15  RAM word-address width; all address arithmetic wraps modulo 2**ADDR_W
// DATA_W  16  RAM word width
// PORTS
// clk        in   1       system clock
// reset      in   1       synchronous, active-high
// reg_sel    in   2       register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL
// reg_wdata  in   DATA_W  register write data
// reg_we     in   1       register write strobe, one cycle
// reg_rdata  out  DATA_W  combinational readback of selected register (CTRL reads {15'b0,busy})
// video_busy in   1       tile_reading|sprite_reading; video owns RAM this cycle
// ram_req    out  1       engine drives ram_addr/ram_wdata/ram_we this cycle (mux select)
// ram_addr   out  ADDR_W  RAM address
// ram_wdata  out  DATA_W  RAM write data
// ram_we     out  1       RAM write enable
// ram_rdata  in   DATA_W  RAM_sync dout (valid one cycle after address presented)
// busy       out  1       transfer in progress
// cpu_hold   out  1       = busy; stalls CPU
// done       out  1       one-cycle pulse when a transfer completes
// BEHAVIOUR
// - Reset: SRC=DST=LEN=0, state IDLE; busy, cpu_hold, done, ram_req, ram_we = 0; ram_addr, ram_wdata = 0.
// - Register writes accepted only in IDLE; writes while busy are ignored. SRC/DST keep low ADDR_W bits.
// - CTRL write with bit0=1 starts: bit1=0 FILL (SRC value is fill data), bit1=1 COPY. busy rises next cycle.
// - Start with LEN=0: no RAM cycles; done pulses 1 cycle after start, busy never asserts.
// - States: IDLE -> (COPY) RD_ISSUE -> RD_WAIT -> WR -> RD_ISSUE..., (FILL) WR -> WR...; last WR -> DONE -> IDLE.
// - RD_ISSUE: if video_busy=0: ram_req=1, ram_addr=src, go RD_WAIT; else stay, ram_req=0.
// - RD_WAIT: ram_req=0; latch ram_rdata unconditionally (RAM_sync returns prior-cycle address), go WR.
// - WR: if video_busy=0: ram_req=1, ram_we=1, ram_addr=dst, ram_wdata=latched/fill; dst+=1, src+=1 (copy),
//   LEN-=1; LEN reaching 0 -> DONE else next word. If video_busy=1: stall, no write, nothing increments.
// - ram_we never asserted while ram_req=0 or video_busy=1; ram_req never asserted with video_busy=1.
// - Throughput with no video contention: FILL 1 word/cycle, COPY 1 word/3 cycles.
// - Addresses wrap 0x7FFF -> 0x0000; overlapping copy proceeds ascending with no special handling.
// - DONE: done=1 for one cycle, busy=0 same cycle, return IDLE; SRC/DST/LEN readback show final values.
// - Reset mid-transfer: abort immediately; no further RAM writes; registers cleared; no done pulse.
// STRUCTURE
// - Shared package: register-select constants (REG_SRC..REG_CTRL), CTRL bit positions, state enum.
// - Single module; no sub-module needed. Platform mux priority: video > engine (ram_req) > CPU.
// TESTING
// - FILL SRC=0x0020,DST=0x6000,LEN=0x0390, no video -> 912 writes of 0x0020 at 0x6000..0x638F, done once.
// - COPY SRC=0x7F00,DST=0x7F40,LEN=4 with RAM preloaded 1,2,3,4 -> 0x7F40..43 = 1,2,3,4; busy 12 cycles.
// - COPY LEN=8 with video_busy toggling every 3 cycles -> data correct, zero writes during video_busy=1.
// - LEN=0 start -> done pulse next cycle, ram_req never asserted, busy stays 0.
// - FILL DST=0x7FFE,LEN=4 -> writes 0x7FFE,0x7FFF,0x0000,0x0001; DST reads back 0x0002.
// - Reset asserted after 3 of 10 fill writes -> no further ram_we, all outputs 0, registers read 0.

Source files
------------

// File: rtl/vram_dma_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_dma_engine_pkg
// Description : Shared constants and state encoding for the VRAM fill/copy
//               engine.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_dma_engine_pkg;

    localparam int unsigned c_ADDR_W    = 15;
    localparam int unsigned c_DATA_W    = 16;
    localparam int unsigned c_REG_SEL_W = 2;

    localparam logic [c_REG_SEL_W-1:0] c_REG_SRC  = 2'd0;
    localparam logic [c_REG_SEL_W-1:0] c_REG_DST  = 2'd1;
    localparam logic [c_REG_SEL_W-1:0] c_REG_LEN  = 2'd2;
    localparam logic [c_REG_SEL_W-1:0] c_REG_CTRL = 2'd3;

    localparam int unsigned c_CTRL_START = 0;
    localparam int unsigned c_CTRL_COPY  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_dma_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_dma_engine_if
// Description : CPU register port, RAM mux port and status lines of the
//               VRAM fill/copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_dma_engine_if
    import vram_dma_engine_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [c_REG_SEL_W-1:0] reg_sel;
    logic [DATA_W-1:0]      reg_wdata;
    logic                   reg_we;
    logic [DATA_W-1:0]      reg_rdata;
    logic                   video_busy;
    logic                   ram_req;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic                   ram_we;
    logic [DATA_W-1:0]      ram_rdata;
    logic                   busy;
    logic                   cpu_hold;
    logic                   done;

    // Engine side
    modport master (
        input  reg_sel, reg_wdata, reg_we, video_busy, ram_rdata,
        output reg_rdata, ram_req, ram_addr, ram_wdata, ram_we,
               busy, cpu_hold, done
    );

    // Platform side (CPU, RAM, video arbiter)
    modport slave (
        output reg_sel, reg_wdata, reg_we, video_busy, ram_rdata,
        input  reg_rdata, ram_req, ram_addr, ram_wdata, ram_we,
               busy, cpu_hold, done
    );

endinterface
`default_nettype wire

// File: rtl/vram_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : vram_dma_engine
// Description : CPU-programmed block fill/copy engine for the video RAM;
//               yields to video fetches and holds the CPU while active.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_dma_engine
    import vram_dma_engine_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    vram_dma_engine_if.master bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_len;
    logic [DATA_W-1:0] r_data;
    logic              r_copy;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_last;

    assign w_start = bus.reg_wdata[c_CTRL_START];
    assign w_last  = (r_len == DATA_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_copy  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.reg_we) begin
                        case (bus.reg_sel)
                            c_REG_SRC: r_src <= bus.reg_wdata[ADDR_W-1:0];
                            c_REG_DST: r_dst <= bus.reg_wdata[ADDR_W-1:0];
                            c_REG_LEN: r_len <= bus.reg_wdata;
                            c_REG_CTRL: begin
                                if (w_start) begin
                                    r_copy <= bus.reg_wdata[c_CTRL_COPY];
                                    // Zero-length transfer completes without ever going busy
                                    if (r_len == '0) begin
                                        r_done  <= 1'b1;
                                        r_state <= ST_DONE;
                                    end else begin
                                        r_busy  <= 1'b1;
                                        r_state <= bus.reg_wdata[c_CTRL_COPY] ? ST_RD_ISSUE : ST_WR;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RD_ISSUE: begin
                    if (!bus.video_busy) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Synchronous RAM returns the word addressed in the previous cycle
                    r_data  <= bus.ram_rdata;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (!bus.video_busy) begin
                        r_dst <= r_dst + ADDR_W'(1);
                        if (r_copy) begin
                            r_src <= r_src + ADDR_W'(1);
                        end
                        r_len <= r_len - DATA_W'(1);
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= r_copy ? ST_RD_ISSUE : ST_WR;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM strobes are gated by video_busy in the same cycle so video always wins
    always_comb begin
        bus.ram_req   = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (r_state)
            ST_RD_ISSUE: begin
                bus.ram_req  = !bus.video_busy;
                bus.ram_addr = r_src;
            end
            ST_WR: begin
                bus.ram_req   = !bus.video_busy;
                bus.ram_we    = !bus.video_busy;
                bus.ram_addr  = r_dst;
                bus.ram_wdata = r_copy ? r_data : DATA_W'(r_src);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_sel)
            c_REG_SRC:  bus.reg_rdata = DATA_W'(r_src);
            c_REG_DST:  bus.reg_rdata = DATA_W'(r_dst);
            c_REG_LEN:  bus.reg_rdata = r_len;
            c_REG_CTRL: bus.reg_rdata = DATA_W'(r_busy);
            default:    bus.reg_rdata = '0;
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.cpu_hold = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vram_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_dma_engine
// Description : Self-checking bench for vram_dma_engine with a synchronous
//               RAM model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_dma_engine;
    import vram_dma_engine_pkg::*;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vram_dma_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_dma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_writes = 0;
    int   n_req    = 0;
    logic vb_toggle = 1'b0;

    // Synchronous RAM: dout reflects the address presented on the previous cycle
    always @(posedge clk) begin
        if (bus.ram_req) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard and bus-rule monitor
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (bus.done) n_done++;
        if (bus.ram_req) begin
            n_req++;
            check("req_while_video", {31'd0, bus.video_busy}, 32'd0);
        end
        if (bus.ram_we) begin
            n_writes++;
            check("we_without_req", {31'd0, bus.ram_req}, 32'd1);
            check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.ram_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("write_data", 32'(bus.ram_wdata), 32'(e[DATA_W-1:0]));
            end
        end
    end

    // video_busy: idle unless toggling every 3 cycles is enabled
    initial begin
        int cnt;
        cnt = 0;
        bus.video_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (vb_toggle) begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    bus.video_busy = ~bus.video_busy;
                end
            end else begin
                cnt = 0;
                bus.video_busy = 1'b0;
            end
        end
    end

    task automatic reg_write(input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        bus.reg_sel   = sel;
        bus.reg_wdata = data;
        bus.reg_we    = 1'b1;
        @(negedge clk);
        bus.reg_we    = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] sel, output logic [15:0] data);
        @(negedge clk);
        bus.reg_sel = sel;
        #1;
        data = bus.reg_rdata;
    endtask

    task automatic wait_done(input string tag, input int budget, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) break;
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_busy"},      {31'd0, bus.busy},     32'd0);
        check({tag, "_cpu_hold"},  {31'd0, bus.cpu_hold}, 32'd0);
        check({tag, "_done"},      {31'd0, bus.done},     32'd0);
        check({tag, "_ram_req"},   {31'd0, bus.ram_req},  32'd0);
        check({tag, "_ram_we"},    {31'd0, bus.ram_we},   32'd0);
        check({tag, "_ram_addr"},  32'(bus.ram_addr),     32'd0);
        check({tag, "_ram_wdata"}, 32'(bus.ram_wdata),    32'd0);
    endtask

    task automatic check_regs_zero(input string tag);
        logic [15:0] d;
        for (int s = 0; s < 4; s++) begin
            reg_read(2'(s), d);
            check($sformatf("%s_reg%0d", tag, s), 32'(d), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] vdata [8];
        int cyc, w0, d0, r0, k;

        bus.reg_sel   = '0;
        bus.reg_wdata = '0;
        bus.reg_we    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        check_regs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // FILL 912 words of 0x0020 at 0x6000
        reg_write(c_REG_SRC, 16'h0020);
        reg_write(c_REG_DST, 16'h6000);
        reg_write(c_REG_LEN, 16'h0390);
        for (int i = 0; i < 912; i++) push_exp(ADDR_W'(32'h6000 + i), 16'h0020);
        w0 = n_writes; d0 = n_done;
        reg_write(c_REG_CTRL, 16'h0001);
        check("fill_busy_rise", {31'd0, bus.busy}, 32'd1);
        check("fill_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
        wait_done("fill", 2000, cyc);
        check("fill_busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("fill_busy_cycles", 32'(cyc), 32'd912);
        @(negedge clk);
        check("fill_done_width", {31'd0, bus.done}, 32'd0);
        check("fill_writes", 32'(n_writes - w0), 32'd912);
        check("fill_done_count", 32'(n_done - d0), 32'd1);
        check("fill_queue_empty", 32'(exp_q.size()), 32'd0);
        reg_read(c_REG_DST, d);  check("fill_dst_final", 32'(d), 32'h6390);
        reg_read(c_REG_LEN, d);  check("fill_len_final", 32'(d), 32'h0000);
        reg_read(c_REG_SRC, d);  check("fill_src_final", 32'(d), 32'h0020);
        reg_read(c_REG_CTRL, d); check("fill_ctrl_idle", 32'(d), 32'h0000);

        // COPY 4 words 0x7F00 -> 0x7F40, 3 cycles per word
        for (int i = 0; i < 4; i++) begin
            mem[ADDR_W'(32'h7F00 + i)] = 16'(i + 1);
            push_exp(ADDR_W'(32'h7F40 + i), 16'(i + 1));
        end
        reg_write(c_REG_SRC, 16'h7F00);
        reg_write(c_REG_DST, 16'h7F40);
        reg_write(c_REG_LEN, 16'h0004);
        reg_write(c_REG_CTRL, 16'h0003);
        wait_done("copy", 100, cyc);
        check("copy_busy_cycles", 32'(cyc), 32'd12);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("copy_mem_%0d", i), 32'(mem[ADDR_W'(32'h7F40 + i)]), 32'(i + 1));
        reg_read(c_REG_SRC, d); check("copy_src_final", 32'(d), 32'h7F04);
        reg_read(c_REG_DST, d); check("copy_dst_final", 32'(d), 32'h7F44);

        // COPY 8 words under video contention
        for (int i = 0; i < 8; i++) begin
            vdata[i] = 16'($urandom_range(0, 16'hFFFF));
            mem[ADDR_W'(32'h1000 + i)] = vdata[i];
            push_exp(ADDR_W'(32'h1100 + i), vdata[i]);
        end
        reg_write(c_REG_SRC, 16'h1000);
        reg_write(c_REG_DST, 16'h1100);
        reg_write(c_REG_LEN, 16'h0008);
        vb_toggle = 1'b1;
        reg_write(c_REG_CTRL, 16'h0003);
        wait_done("vcopy", 500, cyc);
        vb_toggle = 1'b0;
        check("vcopy_was_stalled", {31'd0, cyc > 24}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            check($sformatf("vcopy_mem_%0d", i), 32'(mem[ADDR_W'(32'h1100 + i)]), 32'(vdata[i]));
        check("vcopy_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length start
        reg_write(c_REG_LEN, 16'h0000);
        r0 = n_req;
        reg_write(c_REG_CTRL, 16'h0001);
        check("len0_done", {31'd0, bus.done}, 32'd1);
        check("len0_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("len0_done_width", {31'd0, bus.done}, 32'd0);
        check("len0_busy_after", {31'd0, bus.busy}, 32'd0);
        check("len0_no_req", 32'(n_req - r0), 32'd0);

        // FILL across the top of the address space
        for (int i = 0; i < 4; i++) push_exp(ADDR_W'(32'h7FFE + i), 16'h00AB);
        reg_write(c_REG_SRC, 16'h00AB);
        reg_write(c_REG_DST, 16'h7FFE);
        reg_write(c_REG_LEN, 16'h0004);
        reg_write(c_REG_CTRL, 16'h0001);
        wait_done("wrap", 100, cyc);
        reg_read(c_REG_DST, d); check("wrap_dst_final", 32'(d), 32'h0002);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset after 3 of 10 fill writes
        mem[15'h3003] = 16'hDEAD;
        for (int i = 0; i < 3; i++) push_exp(ADDR_W'(32'h3000 + i), 16'h0055);
        reg_write(c_REG_SRC, 16'h0055);
        reg_write(c_REG_DST, 16'h3000);
        reg_write(c_REG_LEN, 16'h000A);
        w0 = n_writes; d0 = n_done;
        reg_write(c_REG_CTRL, 16'h0001);
        k = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ram_we) k++;
            if (k == 3) break;
            @(negedge clk);
        end
        check("abort_saw_three", 32'(k), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_idle("abort");
        check_regs_zero("abort");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_writes", 32'(n_writes - w0), 32'd3);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_mem_untouched", 32'(mem[15'h3003]), 32'h0000DEAD);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        check("abort_busy_after", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
